// File: rtl/perceptron_unit.sv
// perceptron_unit: UART-addressed single-neuron node holding A, B and ACC with mul, mac and step.
// Build option: `define PERCEPTRON_PASSTHRU_EN to retransmit packets addressed to other nodes.
module perceptron_unit #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] NODE_ADDR    = 8'd100
) (
   input  logic clk,
   input  logic nRst,
   input  logic host_tx,
   output logic uart_tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int GAP_W = $clog2(16 * CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(16 * CLKS_PER_BIT - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] TX_LOAD  = 3'd1;
   localparam logic [2:0] TX_START = 3'd2;
   localparam logic [2:0] TX_DATA  = 3'd3;
   localparam logic [2:0] TX_STOP  = 3'd4;

   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_done_s;

   logic [2:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [47:0]      pkt_q, pkt_d;
   logic             exec_q, exec_d;

   logic [31:0]      a_q, a_d, b_q, b_d, acc_q, acc_d, prod_s;
   logic             tx_req_s;
   logic [47:0]      tx_pkt_s;

   logic [2:0]       tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [2:0]       tx_idx_q, tx_idx_d;
   logic [47:0]      tx_buf_q, tx_buf_d;
   logic             tx_q, tx_d;

   // Receiver: falling-edge start detect, half-bit confirm, mid-bit sampling.
   always_comb begin
      sync1_d    = host_tx;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CNT_W'(1);
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done_s  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = {CNT_W{1'b0}};
            if (prev_q && !sync2_q) rx_state_d = RX_START;
            else                    rx_state_d = RX_IDLE;
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = {CNT_W{1'b0}};
               rx_bit_d   = 3'd0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = {CNT_W{1'b0}};
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               rx_state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_done_s  = sync2_q;
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_STOP;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Packet assembler; an over-long idle gap mid-packet drops the partial packet.
   always_comb begin
      idx_d  = idx_q;
      gap_d  = gap_q;
      pkt_d  = pkt_q;
      exec_d = 1'b0;
      if (rx_done_s) begin
         pkt_d[{idx_q, 3'd0} +: 8] = rx_shift_q;
         gap_d = {GAP_W{1'b0}};
         if (idx_q == 3'd5) begin
            idx_d  = 3'd0;
            exec_d = 1'b1;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else if (idx_q != 3'd0 && rx_state_q == RX_IDLE) begin
         if (gap_q == GAP_LAST) begin
            idx_d = 3'd0;
            gap_d = {GAP_W{1'b0}};
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end else begin
         gap_d = gap_q;
      end
   end

   // Command execution; products keep only the low 32 bits, which equal the signed low word.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      prod_s   = a_q * b_q;
      tx_req_s = 1'b0;
      tx_pkt_s = pkt_q;
      if (exec_q) begin
         if (pkt_q[7:0] == NODE_ADDR) begin
            case (pkt_q[15:8])
               8'd0: a_d = pkt_q[47:16];
               8'd1: b_d = pkt_q[47:16];
               8'd2: begin
                  tx_req_s = 1'b1;
                  tx_pkt_s = {acc_q, 8'd2, NODE_ADDR};
               end
               8'd3: acc_d = 32'd0;
               8'd4: acc_d = a_q + b_q;
               8'd5: acc_d = prod_s;
               8'd6: acc_d = acc_q + prod_s;
               8'd7: acc_d = {31'd0, ~acc_q[31]};
               default: acc_d = acc_q;
            endcase
         end else begin
`ifdef PERCEPTRON_PASSTHRU_EN
            tx_req_s = 1'b1;
`else
            tx_req_s = 1'b0;
`endif
         end
      end else begin
         tx_req_s = 1'b0;
      end
   end

   // Transmitter: one packet buffer, bytes sent back-to-back; requests while busy are dropped.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CNT_W'(1);
      tx_bit_d   = tx_bit_q;
      tx_idx_d   = tx_idx_q;
      tx_buf_d   = tx_buf_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = {CNT_W{1'b0}};
            if (tx_req_s) begin
               tx_buf_d   = tx_pkt_s;
               tx_idx_d   = 3'd0;
               tx_state_d = TX_LOAD;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_LOAD: begin
            tx_cnt_d   = {CNT_W{1'b0}};
            tx_state_d = TX_START;
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = {CNT_W{1'b0}};
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_state_d = TX_START;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = {CNT_W{1'b0}};
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_state_d = (tx_bit_q == 3'd7) ? TX_STOP : TX_DATA;
            end else begin
               tx_state_d = TX_DATA;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = {CNT_W{1'b0}};
               if (tx_idx_q == 3'd5) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_state_d = TX_START;
               end
            end else begin
               tx_state_d = TX_STOP;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_buf_d[{tx_idx_d, tx_bit_d}];
         default:  tx_d = 1'b1;
      endcase
   end

   // State registers; nRst is a synchronous active-high clear.
   always_ff @(posedge clk) begin
      if (nRst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= {CNT_W{1'b0}};
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         idx_q      <= 3'd0;
         gap_q      <= {GAP_W{1'b0}};
         pkt_q      <= 48'd0;
         exec_q     <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         acc_q      <= 32'd0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= {CNT_W{1'b0}};
         tx_bit_q   <= 3'd0;
         tx_idx_q   <= 3'd0;
         tx_buf_q   <= 48'd0;
         tx_q       <= 1'b1;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         pkt_q      <= pkt_d;
         exec_q     <= exec_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_idx_q   <= tx_idx_d;
         tx_buf_q   <= tx_buf_d;
         tx_q       <= tx_d;
      end
   end

   assign uart_tx = tx_q;

endmodule

// File: tb/tb_perceptron_unit.sv
// tb_perceptron_unit: drives command packets over a bench UART and decodes uart_tx into a byte queue.
// Expectations come from a vector table and, for random traffic, a plain-arithmetic node model.
module tb_perceptron_unit;

   localparam int         CPB  = 10;
   localparam logic [7:0] NODE = 8'd100;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  cmd;
      logic [31:0] pl;
      logic [31:0] exp_acc;
   } vec_t;

   logic clk = 1'b0;
   logic nRst;
   logic host_tx;
   logic uart_tx;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] m_a, m_b, m_acc;
   vec_t        tbl[$];

   perceptron_unit #(.CLKS_PER_BIT(CPB), .NODE_ADDR(NODE)) dut (
      .clk     (clk),
      .nRst    (nRst),
      .host_tx (host_tx),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Decode every frame on uart_tx at mid-bit and verify its stop bit.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge uart_tx);
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (CPB) @(negedge clk);
         check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
         got_q.push_back(b);
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      host_tx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         host_tx = b[i];
         repeat (CPB) @(negedge clk);
      end
      host_tx = stop;
      repeat (CPB) @(negedge clk);
      host_tx = 1'b1;
   endtask

   task automatic send_packet(input logic [7:0] a, input logic [7:0] c, input logic [31:0] p, input int gap_bits);
      send_byte(a, 1'b1);
      send_byte(c, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(p[8*i +: 8], 1'b1);
      repeat (gap_bits * CPB) @(negedge clk);
   endtask

   task automatic wait_bytes(input int n);
      int budget = (n * 10 + 30) * CPB;
      while (got_q.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
   endtask

   task automatic apply_vec(input vec_t v);
      logic [7:0] eb [6];
      int n = 0;
      if (v.addr == NODE && v.cmd == 8'd2) begin
         n = 6;
         eb[0] = NODE; eb[1] = 8'd2;
         for (int i = 0; i < 4; i++) eb[2+i] = v.exp_acc[8*i +: 8];
      end
`ifdef PERCEPTRON_PASSTHRU_EN
      else if (v.addr != NODE) begin
         n = 6;
         eb[0] = v.addr; eb[1] = v.cmd;
         for (int i = 0; i < 4; i++) eb[2+i] = v.pl[8*i +: 8];
      end
`endif
      send_packet(v.addr, v.cmd, v.pl, 3);
      if (n > 0) wait_bytes(n);
      else repeat (12 * CPB) @(negedge clk);
      check("rx_count", 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (got_q.size() > 0) check("rx_byte", {24'd0, got_q.pop_front()}, {24'd0, eb[i]});
      end
      got_q.delete();
   endtask

   task automatic model_apply(input logic [7:0] a, input logic [7:0] c, input logic [31:0] p);
      longint prod;
      prod = longint'($signed(m_a)) * longint'($signed(m_b));
      if (a != NODE) begin
`ifdef PERCEPTRON_PASSTHRU_EN
         exp_q.push_back(a); exp_q.push_back(c);
         for (int i = 0; i < 4; i++) exp_q.push_back(p[8*i +: 8]);
`endif
      end else begin
         case (c)
            8'd0: m_a = p;
            8'd1: m_b = p;
            8'd2: begin
               exp_q.push_back(NODE); exp_q.push_back(8'd2);
               for (int i = 0; i < 4; i++) exp_q.push_back(m_acc[8*i +: 8]);
            end
            8'd3: m_acc = 32'd0;
            8'd4: m_acc = m_a + m_b;
            8'd5: m_acc = prod[31:0];
            8'd6: m_acc = m_acc + prod[31:0];
            8'd7: m_acc = ($signed(m_acc) >= 0) ? 32'd1 : 32'd0;
            default: m_acc = m_acc;
         endcase
      end
   endtask

   initial begin
      logic [7:0]  ra, rc;
      logic [31:0] rp;
      int          budget;

      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd0, 32'd1, 32'd0});
      tbl.push_back('{8'd100, 8'd1, 32'd1, 32'd0});
      tbl.push_back('{8'd100, 8'd5, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd6, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd2});
      tbl.push_back('{8'd101, 8'd0, 32'd1, 32'd0});
      tbl.push_back('{8'd101, 8'd1, 32'd1, 32'd0});
      tbl.push_back('{8'd101, 8'd5, 32'd0, 32'd0});
      tbl.push_back('{8'd101, 8'd6, 32'd0, 32'd0});
      tbl.push_back('{8'd101, 8'd2, 32'd0, 32'd0});
      tbl.push_back('{8'd101, 8'd3, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd2});
      tbl.push_back('{8'd100, 8'd0, 32'hFFFF_FFFF, 32'd0});
      tbl.push_back('{8'd100, 8'd1, 32'd3, 32'd0});
      tbl.push_back('{8'd100, 8'd5, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'hFFFF_FFFD});
      tbl.push_back('{8'd100, 8'd7, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd0, 32'h8000_0000, 32'd0});
      tbl.push_back('{8'd100, 8'd1, 32'd2, 32'd0});
      tbl.push_back('{8'd100, 8'd5, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd0, 32'd7, 32'd0});
      tbl.push_back('{8'd100, 8'd1, 32'hFFFF_FFF0, 32'd0});
      tbl.push_back('{8'd100, 8'd4, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'hFFFF_FFF7});
      tbl.push_back('{8'd100, 8'd9, 32'd5, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'hFFFF_FFF7});
      tbl.push_back('{8'd100, 8'd6, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'hFFFF_FF87});
      tbl.push_back('{8'd100, 8'd3, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd7, 32'd0, 32'd0});
      tbl.push_back('{8'd100, 8'd2, 32'd0, 32'd1});

      nRst = 1'b1;
      host_tx = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
      nRst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_uart_tx", {31'd0, uart_tx}, 32'd1);

      foreach (tbl[i]) apply_vec(tbl[i]);

      // Reset in the middle of a packet must leave no stale bytes behind.
      send_byte(8'd100, 1'b1);
      send_byte(8'd0, 1'b1);
      send_byte(8'd5, 1'b1);
      nRst = 1'b1;
      repeat (10000) @(negedge clk);
      nRst = 0;
      repeat (5) @(negedge clk);
      for (int i = 1; i <= 5; i++) apply_vec(tbl[i]);

      // A byte with a low stop bit is discarded.
      send_byte(8'd100, 1'b0);
      repeat (3 * CPB) @(negedge clk);
      apply_vec('{8'd100, 8'd2, 32'd0, 32'd2});

      // A partial packet followed by a long idle gap is dropped.
      send_byte(8'd100, 1'b1);
      send_byte(8'd3, 1'b1);
      repeat (20 * CPB) @(negedge clk);
      apply_vec('{8'd100, 8'd2, 32'd0, 32'd2});

      // Reset while uart_tx is low returns the line high on the next clock.
      send_packet(8'd100, 8'd2, 32'd0, 0);
      budget = 20 * CPB;
      while (uart_tx && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("tx_low_before_reset", {31'd0, uart_tx}, 32'd0);
      nRst = 1'b1;
      @(negedge clk);
      check("tx_high_after_reset", {31'd0, uart_tx}, 32'd1);
      repeat (4) @(negedge clk);
      nRst = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      got_q.delete();

      // Random traffic against the reference model, packets close together.
      m_a = 32'd0; m_b = 32'd0; m_acc = 32'd0;
      for (int k = 0; k < 14; k++) begin
         ra = ($urandom_range(0, 5) == 0) ? 8'd101 : NODE;
         rc = 8'($urandom_range(0, 8));
         if (rc == 8'd8) rc = 8'($urandom_range(8, 255));
         rp = $urandom;
         if (k == 13) begin
            ra = NODE;
            rc = 8'd2;
         end
         model_apply(ra, rc, rp);
         send_packet(ra, rc, rp, 3);
      end
      wait_bytes(exp_q.size());
      repeat (12 * CPB) @(negedge clk);
      check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         check("rand_byte", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
